// File: rtl/big_fv_bank_req_arbiter_pkg.sv
// Shared definitions for the big feature-value bank request arbiter.
// Holds the default sizing constants, the arbiter state encoding and a small
// saturating-increment helper.
package big_fv_bank_req_arbiter_pkg;

  localparam int unsigned NumEdgePe   = 4;
  localparam int unsigned MaxNodeId   = 1024;
  localparam int unsigned NodeIdW     = $clog2(MaxNodeId);
  localparam int unsigned FvBandwidth = 128;
  localparam int unsigned WbMaxConsec = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWbBusy,
    StRdBusy
  } arb_state_e;

  // Increment that sticks at max instead of wrapping.
  function automatic int unsigned sat_inc(int unsigned val, int unsigned max);
    return (val >= max) ? max : val + 1;
  endfunction

endpackage

// File: rtl/big_fv_bank_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   i_req   - request vector
//   i_ptr   - highest-priority index this cycle
//   o_gnt   - one-hot grant (first set request at index >= i_ptr, wrapping)
//   o_idx   - encoded index of the grant
//   o_valid - some request was found
module big_fv_bank_req_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_cand;

  // NUM_REQ is a power of two, so the index sum wraps naturally.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = i_ptr + IDX_W'(i);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/big_fv_bank_req_arbiter.sv
// Arbitrates the single request port of the big feature-value SRAM bank
// between NUM_PE Edge-PE readers and one write-back stream.
// Ports:
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_arb_en             - new grants allowed (update phase only)
//   i_rd_req_*           - per-PE read request / node id (PE0 in LSBs)
//   o_rd_req_ready       - one-hot read grant pulse
//   i_wb_*, o_wb_ready   - write-back beat stream and its acceptance
//   i_bank_rd_eos        - bank finished the current read stream
//   o_out_*              - registered bank request packet
//   o_busy               - a bank transaction is in flight
//   o_err_wb_gap         - sticky: write-back stream stalled mid-transaction
module big_fv_bank_req_arbiter
  import big_fv_bank_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PE        = NumEdgePe,
  parameter int unsigned NODE_ID_W     = NodeIdW,
  parameter int unsigned FV_W          = FvBandwidth,
  parameter int unsigned WB_MAX_CONSEC = WbMaxConsec
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_arb_en,
  input  logic [NUM_PE-1:0]           i_rd_req_valid,
  input  logic [NUM_PE*NODE_ID_W-1:0] i_rd_req_node_id,
  output logic [NUM_PE-1:0]           o_rd_req_ready,
  input  logic                        i_wb_valid,
  input  logic [NODE_ID_W-1:0]        i_wb_node_id,
  input  logic [FV_W-1:0]             i_wb_data,
  input  logic                        i_wb_eos,
  output logic                        o_wb_ready,
  input  logic                        i_bank_rd_eos,
  output logic                        o_out_valid,
  output logic                        o_out_rd_wr,
  output logic [NODE_ID_W-1:0]        o_out_node_id,
  output logic [$clog2(NUM_PE)-1:0]   o_out_pe_tag,
  output logic [FV_W-1:0]             o_out_data,
  output logic                        o_out_wr_eos,
  output logic                        o_busy,
  output logic                        o_err_wb_gap
);

  localparam int unsigned TAG_W    = $clog2(NUM_PE);
  localparam int unsigned CONSEC_W = $clog2(WB_MAX_CONSEC + 1);

  arb_state_e           r_state;
  logic [TAG_W-1:0]     r_rr_ptr;
  logic [CONSEC_W-1:0]  r_wb_consec;
  logic                 r_out_valid;
  logic                 r_out_rd_wr;
  logic [NODE_ID_W-1:0] r_out_node_id;
  logic [TAG_W-1:0]     r_out_pe_tag;
  logic [FV_W-1:0]      r_out_data;
  logic                 r_out_wr_eos;
  logic                 r_err_wb_gap;

  logic [NUM_PE-1:0]    w_rr_gnt;
  logic [TAG_W-1:0]     w_rr_idx;
  logic                 w_any_rd;
  logic                 w_wb_win;
  logic                 w_idle_arb;
  logic                 w_grant_wb;
  logic                 w_grant_rd;
  logic [CONSEC_W-1:0]  w_consec_inc;
  logic [NODE_ID_W-1:0] w_rd_node;

  big_fv_bank_req_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_PE)
  ) u_rr_arbiter (
    .i_req   (i_rd_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_any_rd)
  );

  // Writes win unless a reader has already been starved by WB_MAX_CONSEC writes.
  assign w_wb_win     = i_wb_valid &&
                        !(w_any_rd && (r_wb_consec == CONSEC_W'(WB_MAX_CONSEC)));
  assign w_idle_arb   = !i_reset && (r_state == StIdle) && i_arb_en;
  assign w_grant_wb   = w_idle_arb && w_wb_win;
  assign w_grant_rd   = w_idle_arb && w_any_rd && !w_wb_win;
  assign w_consec_inc = CONSEC_W'(sat_inc(32'(r_wb_consec), WB_MAX_CONSEC));
  assign w_rd_node    = i_rd_req_node_id[w_rr_idx*NODE_ID_W +: NODE_ID_W];

  assign o_wb_ready     = w_grant_wb || (!i_reset && (r_state == StWbBusy));
  assign o_rd_req_ready = w_grant_rd ? w_rr_gnt : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_wb_consec   <= '0;
      r_out_valid   <= 1'b0;
      r_out_rd_wr   <= 1'b0;
      r_out_node_id <= '0;
      r_out_pe_tag  <= '0;
      r_out_data    <= '0;
      r_out_wr_eos  <= 1'b0;
      r_err_wb_gap  <= 1'b0;
    end else begin
      r_out_wr_eos <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_out_valid <= 1'b0;
          if (w_grant_wb) begin
            r_out_valid   <= 1'b1;
            r_out_rd_wr   <= 1'b1;
            r_out_node_id <= i_wb_node_id;
            r_out_data    <= i_wb_data;
            r_out_wr_eos  <= i_wb_eos;
            r_wb_consec   <= w_any_rd ? w_consec_inc : '0;
            if (!i_wb_eos) r_state <= StWbBusy;
          end else if (w_grant_rd) begin
            r_out_valid   <= 1'b1;
            r_out_rd_wr   <= 1'b0;
            r_out_node_id <= w_rd_node;
            r_out_pe_tag  <= w_rr_idx;
            r_rr_ptr      <= w_rr_idx + TAG_W'(1);
            r_wb_consec   <= '0;
            r_state       <= StRdBusy;
          end
        end
        StWbBusy: begin
          r_out_valid <= i_wb_valid;
          if (i_wb_valid) begin
            r_out_rd_wr   <= 1'b1;
            r_out_node_id <= i_wb_node_id;
            r_out_data    <= i_wb_data;
            r_out_wr_eos  <= i_wb_eos;
            if (i_wb_eos) r_state <= StIdle;
          end else begin
            // Bank writes every cycle; a bubble here loses data.
            r_err_wb_gap <= 1'b1;
          end
        end
        StRdBusy: begin
          r_out_valid <= 1'b0;
          if (i_bank_rd_eos) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_rd_wr   = r_out_rd_wr;
  assign o_out_node_id = r_out_node_id;
  assign o_out_pe_tag  = r_out_pe_tag;
  assign o_out_data    = r_out_data;
  assign o_out_wr_eos  = r_out_wr_eos;
  assign o_busy        = (r_state != StIdle);
  assign o_err_wb_gap  = r_err_wb_gap;

endmodule

// File: tb/tb_big_fv_bank_req_arbiter.sv
module tb_big_fv_bank_req_arbiter;

  localparam int unsigned NUM_PE        = 4;
  localparam int unsigned NODE_ID_W     = 10;
  localparam int unsigned FV_W          = 128;
  localparam int unsigned WB_MAX_CONSEC = 4;
  localparam int unsigned TAG_W         = $clog2(NUM_PE);

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        arb_en;
  logic [NUM_PE-1:0]           rd_valid;
  logic [NUM_PE*NODE_ID_W-1:0] rd_node;
  logic [NUM_PE-1:0]           rd_ready;
  logic                        wb_valid;
  logic [NODE_ID_W-1:0]        wb_node;
  logic [FV_W-1:0]             wb_data;
  logic                        wb_eos;
  logic                        wb_ready;
  logic                        bank_rd_eos;
  logic                        out_valid;
  logic                        out_rd_wr;
  logic [NODE_ID_W-1:0]        out_node;
  logic [TAG_W-1:0]            out_tag;
  logic [FV_W-1:0]             out_data;
  logic                        out_eos;
  logic                        busy;
  logic                        err_gap;

  always #5 clk = ~clk;

  big_fv_bank_req_arbiter #(
    .NUM_PE        (NUM_PE),
    .NODE_ID_W     (NODE_ID_W),
    .FV_W          (FV_W),
    .WB_MAX_CONSEC (WB_MAX_CONSEC)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_arb_en         (arb_en),
    .i_rd_req_valid   (rd_valid),
    .i_rd_req_node_id (rd_node),
    .o_rd_req_ready   (rd_ready),
    .i_wb_valid       (wb_valid),
    .i_wb_node_id     (wb_node),
    .i_wb_data        (wb_data),
    .i_wb_eos         (wb_eos),
    .o_wb_ready       (wb_ready),
    .i_bank_rd_eos    (bank_rd_eos),
    .o_out_valid      (out_valid),
    .o_out_rd_wr      (out_rd_wr),
    .o_out_node_id    (out_node),
    .o_out_pe_tag     (out_tag),
    .o_out_data       (out_data),
    .o_out_wr_eos     (out_eos),
    .o_busy           (busy),
    .o_err_wb_gap     (err_gap)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: mode 0 = idle, 1 = write stream, 2 = read in flight.
  int                   m_mode;
  int                   m_ptr;
  int                   m_consec;
  bit                   m_err;
  logic                 e_valid;
  logic                 e_rdwr;
  logic [NODE_ID_W-1:0] e_node;
  logic [TAG_W-1:0]     e_tag;
  logic [FV_W-1:0]      e_data;
  logic                 e_eos;
  bit                   g_wb_acc;

  // Last observed DUT values, for directed spot checks.
  logic [NUM_PE-1:0]    d_rd_ready;
  logic                 d_wb_ready;
  logic                 d_valid;
  logic                 d_eos;
  logic [NODE_ID_W-1:0] d_node;
  logic [TAG_W-1:0]     d_tag;
  logic                 d_busy;
  logic                 d_err;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle();
    logic [NUM_PE-1:0] x_rd;
    logic              x_wb;
    bit                any_rd;
    int                k;
    #1;
    x_rd   = '0;
    x_wb   = 1'b0;
    any_rd = (rd_valid != '0);
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_consec = 0; m_err = 0;
      e_valid = 0; e_rdwr = 0; e_node = '0; e_tag = '0; e_data = '0; e_eos = 0;
    end else begin
      e_eos = 1'b0;
      case (m_mode)
        0: begin
          e_valid = 1'b0;
          if (arb_en) begin
            if (wb_valid && !(any_rd && m_consec == WB_MAX_CONSEC)) begin
              x_wb = 1'b1;
              e_valid = 1'b1; e_rdwr = 1'b1; e_node = wb_node; e_data = wb_data; e_eos = wb_eos;
              m_mode = wb_eos ? 0 : 1;
              if (!any_rd) m_consec = 0;
              else if (m_consec < WB_MAX_CONSEC) m_consec = m_consec + 1;
            end else if (any_rd) begin
              k = -1;
              for (int i = 0; i < NUM_PE; i++)
                if (k < 0 && rd_valid[(m_ptr + i) % NUM_PE]) k = (m_ptr + i) % NUM_PE;
              x_rd[k] = 1'b1;
              e_valid = 1'b1; e_rdwr = 1'b0;
              e_node = rd_node[k*NODE_ID_W +: NODE_ID_W];
              e_tag = TAG_W'(k);
              m_ptr = (k + 1) % NUM_PE;
              m_consec = 0;
              m_mode = 2;
            end
          end
        end
        1: begin
          x_wb = 1'b1;
          if (wb_valid) begin
            e_valid = 1'b1; e_rdwr = 1'b1; e_node = wb_node; e_data = wb_data; e_eos = wb_eos;
            if (wb_eos) m_mode = 0;
          end else begin
            m_err = 1'b1;
            e_valid = 1'b0;
          end
        end
        default: begin
          e_valid = 1'b0;
          if (bank_rd_eos) m_mode = 0;
        end
      endcase
    end
    g_wb_acc   = x_wb && wb_valid;
    d_rd_ready = rd_ready;
    d_wb_ready = wb_ready;
    chk("rd_req_ready", rd_ready, x_rd);
    chk("wb_ready", wb_ready, x_wb);
    @(posedge clk);
    #1;
    chk("bank_pkt", {out_valid, out_rd_wr, out_node, out_tag, out_data, out_eos},
        {e_valid, e_rdwr, e_node, e_tag, e_data, e_eos});
    chk("busy", busy, m_mode != 0);
    chk("err_wb_gap", err_gap, m_err);
    d_valid = out_valid; d_eos = out_eos; d_node = out_node; d_tag = out_tag;
    d_busy = busy; d_err = err_gap;
    rd_valid = rd_valid & ~x_rd;  // requester withdraws after its grant
    @(negedge clk);
  endtask

  initial begin
    int          cnt_v;
    int          cnt_e;
    int          wb_left;
    logic [NUM_PE-1:0] acc_rd;
    logic        acc_wb;

    reset = 1'b1; arb_en = 1'b0; rd_valid = '0; rd_node = '0;
    wb_valid = 1'b0; wb_node = '0; wb_data = '0; wb_eos = 1'b0; bank_rd_eos = 1'b0;
    @(negedge clk);
    run_cycle();
    run_cycle();
    chk("reset_valid", d_valid, 1'b0);
    chk("reset_busy", d_busy, 1'b0);
    reset = 1'b0;

    // Round-robin between PE0 and PE2 starting from pointer 0.
    arb_en = 1'b1;
    rd_node[0*NODE_ID_W +: NODE_ID_W] = 10'h011;
    rd_node[2*NODE_ID_W +: NODE_ID_W] = 10'h033;
    rd_valid = 4'b0101;
    run_cycle();
    chk("rr_first_grant", d_rd_ready, 4'b0001);
    chk("rr_first_tag", d_tag, 2'd0);
    run_cycle();
    chk("rd_busy_valid_low", d_valid, 1'b0);
    bank_rd_eos = 1'b1; run_cycle(); bank_rd_eos = 1'b0;
    run_cycle();
    chk("rr_second_grant", d_rd_ready, 4'b0100);
    chk("rr_second_tag", d_tag, 2'd2);
    run_cycle();
    bank_rd_eos = 1'b1; run_cycle(); bank_rd_eos = 1'b0;

    // Eight-beat write-back stream to node 0x14.
    cnt_v = 0; cnt_e = 0;
    wb_node = 10'h014;
    for (int b = 1; b <= 8; b++) begin
      wb_valid = 1'b1;
      wb_data  = {$urandom, $urandom, $urandom, $urandom};
      wb_eos   = (b == 8);
      run_cycle();
      cnt_v += int'(d_valid);
      cnt_e += int'(d_eos);
    end
    wb_valid = 1'b0; wb_eos = 1'b0;
    chk("wb8_valid_beats", cnt_v, 8);
    chk("wb8_eos_count", cnt_e, 1);
    chk("wb8_last_eos", d_eos, 1'b1);
    chk("wb8_node", d_node, 10'h014);
    run_cycle();
    chk("wb8_idle_after", d_busy, 1'b0);

    // Write starvation limit with PE1 pending.
    rd_node[1*NODE_ID_W +: NODE_ID_W] = 10'h02a;
    rd_valid = 4'b0010;
    wb_valid = 1'b1; wb_eos = 1'b1; wb_node = 10'h015;
    cnt_v = 0;
    for (int i = 0; i < 4; i++) begin
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      run_cycle();
      cnt_v += int'(d_wb_ready);
    end
    chk("consec_wb_grants", cnt_v, 4);
    run_cycle();
    chk("consec_rd_grant", d_rd_ready, 4'b0010);
    chk("consec_rd_tag", d_tag, 2'd1);
    bank_rd_eos = 1'b1; run_cycle(); bank_rd_eos = 1'b0;
    run_cycle();
    chk("consec_wb_resume", d_wb_ready, 1'b1);
    wb_valid = 1'b0; wb_eos = 1'b0;
    run_cycle();

    // One-cycle gap inside a write stream.
    wb_node = 10'h007;
    wb_valid = 1'b1; wb_data = {4{32'h1111_0001}}; run_cycle();
    wb_data = {4{32'h2222_0002}}; run_cycle();
    wb_valid = 1'b0; run_cycle();
    chk("gap_err_set", d_err, 1'b1);
    chk("gap_valid_low", d_valid, 1'b0);
    chk("gap_node_held", d_node, 10'h007);
    wb_valid = 1'b1; wb_data = {4{32'h3333_0003}}; run_cycle();
    wb_eos = 1'b1; wb_data = {4{32'h4444_0004}}; run_cycle();
    wb_valid = 1'b0; wb_eos = 1'b0; run_cycle();
    chk("gap_err_sticky", d_err, 1'b1);

    // Arbitration disabled with everything requesting.
    arb_en = 1'b0;
    for (int p = 0; p < NUM_PE; p++) rd_node[p*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'(10'h100 + p);
    rd_valid = 4'b1111;
    wb_valid = 1'b1; wb_eos = 1'b1; wb_node = 10'h03c; wb_data = {4{32'hcafe_f00d}};
    acc_rd = '0; acc_wb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      acc_rd |= d_rd_ready;
      acc_wb |= d_wb_ready;
    end
    chk("arb_off_rd", acc_rd, 4'b0000);
    chk("arb_off_wb", acc_wb, 1'b0);
    arb_en = 1'b1;
    run_cycle();
    chk("arb_on_wb_first", d_wb_ready, 1'b1);
    chk("arb_on_no_rd", d_rd_ready, 4'b0000);
    wb_valid = 1'b0; wb_eos = 1'b0;
    bank_rd_eos = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle();
    bank_rd_eos = 1'b0;

    // Reset while a read is in flight; pointer must return to 0.
    rd_node[2*NODE_ID_W +: NODE_ID_W] = 10'h055;
    rd_valid = 4'b0100;
    run_cycle();
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    chk("rst_mid_valid", d_valid, 1'b0);
    chk("rst_mid_busy", d_busy, 1'b0);
    chk("rst_mid_err", d_err, 1'b0);
    rd_valid = 4'b1010;
    run_cycle();
    chk("rst_ptr_zero", d_rd_ready, 4'b0010);
    bank_rd_eos = 1'b1; run_cycle(); bank_rd_eos = 1'b0;

    // Randomized traffic against the model.
    wb_left = 0;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      arb_en      = ($urandom_range(0, 9) != 0);
      bank_rd_eos = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < NUM_PE; p++) begin
        if (!rd_valid[p] && $urandom_range(0, 5) == 0) begin
          rd_valid[p] = 1'b1;
          rd_node[p*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'($urandom);
        end
      end
      if (wb_left == 0 && $urandom_range(0, 3) == 0) begin
        wb_left = $urandom_range(1, 6);
        wb_node = NODE_ID_W'($urandom);
      end
      wb_valid = (wb_left != 0) && ($urandom_range(0, 19) != 0);
      wb_data  = {$urandom, $urandom, $urandom, $urandom};
      wb_eos   = (wb_left == 1);
      run_cycle();
      if (g_wb_acc) wb_left--;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
